// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the helper that classifies long-running operations.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    function automatic logic is_multi(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// clock after start, ready once all WIDTH bits have been produced.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic             run;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= 1'b0;
            count <= '0;
        end else if (abort) begin
            run   <= 1'b0;
            count <= '0;
        end else if (start) begin
            run   <= 1'b1;
            count <= '0;
        end else if (run) begin
            if (count == LAST) run <= 1'b0;
            else               count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (run && (count != LAST)) begin
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign ready     = run && (count == LAST);

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: multi-cycle signed/unsigned multiply, iterative
// divide, direct HI/LO moves, with annul and stall handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             annul_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic             stall_o
);

    localparam int MW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [MW-1:0] MUL_LAST = MW'(MUL_STAGES - 1);

    state_e state, state_nx;
    logic accept, mul_start, div_start, mul_wr, div_wr, mthi_wr, mtlo_wr;
    logic done_nx, dbz_nx;
    logic sgn_mul, sgn_div, dvd_neg, dvs_neg;
    logic neg_q_p0, neg_r_p0;
    logic [MW-1:0] mul_cnt;
    logic signed [2*WIDTH-1:0] mul_a_p0, mul_b_p0, prod;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, quo, rem;
    logic div_ready;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign sgn_mul = (op_i == OP_MULT);
    assign sgn_div = (op_i == OP_DIV);
    assign dvd_neg = sgn_div & src1_i[WIDTH-1];
    assign dvs_neg = sgn_div & src2_i[WIDTH-1];
    assign dvd_mag = cond_neg(src1_i, dvd_neg);
    assign dvs_mag = cond_neg(src2_i, dvs_neg);

    assign accept  = start_i & (state == ST_IDLE) & ~annul_i;
    assign busy_o  = (state != ST_IDLE);
    assign stall_o = busy_o | (start_i & is_multi(op_i) & ~annul_i);

    // Operands are extended to 2*WIDTH so the low half of one product covers both signednesses.
    assign prod = mul_a_p0 * mul_b_p0;

    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        div_start = 1'b0;
        mul_wr    = 1'b0;
        div_wr    = 1'b0;
        mthi_wr   = 1'b0;
        mtlo_wr   = 1'b0;
        done_nx   = 1'b0;
        dbz_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            mul_start = 1'b1;
                            state_nx  = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src2_i == '0) begin
                                done_nx = 1'b1;
                                dbz_nx  = 1'b1;
                            end else begin
                                div_start = 1'b1;
                                state_nx  = ST_DIV;
                            end
                        end
                        OP_MTHI: mthi_wr = 1'b1;
                        OP_MTLO: mtlo_wr = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (annul_i) begin
                    state_nx = ST_IDLE;
                end else if (mul_cnt == MUL_LAST) begin
                    mul_wr   = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (annul_i) begin
                    state_nx = ST_IDLE;
                end else if (div_ready) begin
                    div_wr   = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // p0: operands and result signs captured at the accept edge
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mul_a_p0 <= {{WIDTH{sgn_mul & src1_i[WIDTH-1]}}, src1_i};
            mul_b_p0 <= {{WIDTH{sgn_mul & src2_i[WIDTH-1]}}, src2_i};
        end
        if (div_start) begin
            neg_q_p0 <= dvd_neg ^ dvs_neg;
            neg_r_p0 <= dvd_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mul_cnt <= '0;
            done_o  <= 1'b0;
            dbz_o   <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            state  <= state_nx;
            done_o <= done_nx;
            dbz_o  <= dbz_nx;
            if (mul_start)            mul_cnt <= '0;
            else if (state == ST_MUL) mul_cnt <= mul_cnt + MW'(1);
            if (mul_wr) begin
                {hi_o, lo_o} <= prod;
            end else if (div_wr) begin
                hi_o <= cond_neg(rem, neg_r_p0);
                lo_o <= cond_neg(quo, neg_q_p0);
            end else if (mthi_wr) begin
                hi_o <= src1_i;
            end else if (mtlo_wr) begin
                lo_o <= src1_i;
            end
        end
    end

    muldiv_div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (annul_i),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .quotient  (quo),
        .remainder (rem),
        .ready     (div_ready)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic model
// of HI/LO results, latencies and handshake behaviour.
module tb_muldiv_unit;

    localparam int WIDTH      = 32;
    localparam int MUL_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst, start_i, annul_i;
    logic [2:0]  op_i;
    logic [31:0] src1_i, src2_i;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, done_o, dbz_o, stall_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_hi, m_lo;

    muldiv_unit #(.WIDTH(WIDTH), .MUL_STAGES(MUL_STAGES)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .annul_i (annul_i),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .dbz_o   (dbz_o),
        .stall_o (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected HI/LO, dbz flag and done cycle (0 = no done pulse) for one request.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz, output int lat);
        int sa, sb;
        longint sp;
        longint unsigned up;
        hi  = m_hi;
        lo  = m_lo;
        dbz = 1'b0;
        lat = 0;
        sa  = a;
        sb  = b;
        case (op)
            3'd0: begin
                sp = longint'(sa) * longint'(sb);
                {hi, lo} = sp;
                lat = MUL_STAGES + 1;
            end
            3'd1: begin
                up = 64'(a) * 64'(b);
                {hi, lo} = up;
                lat = MUL_STAGES + 1;
            end
            3'd2: begin
                if (b == 0) begin
                    dbz = 1'b1; lat = 1;
                end else begin
                    lat = WIDTH + 2;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        lo = 32'h8000_0000; hi = 0;
                    end else begin
                        lo = sa / sb; hi = sa % sb;
                    end
                end
            end
            3'd3: begin
                if (b == 0) begin
                    dbz = 1'b1; lat = 1;
                end else begin
                    lat = WIDTH + 2;
                    lo = a / b; hi = a % b;
                end
            end
            3'd4: hi = a;
            default: lo = a;
        endcase
    endfunction

    // Called just after a rising edge; drives one request in cycle 0 and follows it to completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eh, el;
        logic edbz;
        int lat, busy_cnt, c;
        model(op, a, b, eh, el, edbz, lat);
        op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
        @(negedge clk);
        check({tag, "_stall"}, stall_o, (op <= 3'd3));
        @(posedge clk); #1;
        start_i = 1'b0;
        if (lat == 0) begin
            @(negedge clk);
            check({tag, "_hi"}, hi_o, eh);
            check({tag, "_lo"}, lo_o, el);
            check({tag, "_done"}, done_o, 1'b0);
            check({tag, "_busy"}, busy_o, 1'b0);
        end else begin
            busy_cnt = 0;
            for (c = 1; c <= 100; c++) begin
                @(negedge clk);
                if (done_o) break;
                if (busy_o) busy_cnt++;
            end
            check({tag, "_done_cycle"}, c, lat);
            check({tag, "_busy_cycles"}, busy_cnt, lat - 1);
            check({tag, "_busy_at_done"}, busy_o, 1'b0);
            check({tag, "_dbz"}, dbz_o, edbz);
            check({tag, "_hi"}, hi_o, eh);
            check({tag, "_lo"}, lo_o, el);
            @(negedge clk);
            check({tag, "_pulse"}, {done_o, dbz_o}, 2'b00);
        end
        m_hi = eh;
        m_lo = el;
        @(posedge clk); #1;
    endtask

    initial begin
        int done_seen, first, second;
        logic [31:0] a, b, a2, b2, eh, el, eh2, el2;
        logic edbz;
        int lat;
        logic [2:0] op;

        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 3'd0; src1_i = '0; src2_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", hi_o, 32'h0);
        check("reset_lo", lo_o, 32'h0);
        check("reset_flags", {busy_o, done_o, dbz_o, stall_o}, 4'b0000);
        m_hi = 0; m_lo = 0;
        @(posedge clk); #1;

        run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0005, "mult_neg");
        check("mult_neg_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
        check("div_neg_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd100, 32'd0, "divu_dbz");
        check("divu_dbz_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

        // Annul a divide in cycle 10, then move into HI the next cycle.
        done_seen = 0;
        op_i = 3'd2; src1_i = 32'd1000; src2_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) annul_i = 1'b1;
            @(negedge clk);
            done_seen += int'(done_o);
            if (c == 10) check("annul_busy_c10", busy_o, 1'b1);
            @(posedge clk); #1;
        end
        annul_i = 1'b0;
        op_i = 3'd4; src1_i = 32'h1234; start_i = 1'b1;
        @(negedge clk);
        check("annul_busy_c11", busy_o, 1'b0);
        check("annul_no_done", done_seen + int'(done_o), 0);
        check("annul_hilo", {hi_o, lo_o}, {m_hi, m_lo});
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("annul_mthi_hi", hi_o, 32'h1234);
        check("annul_mthi_lo", lo_o, m_lo);
        m_hi = 32'h1234;
        @(posedge clk); #1;

        // Reset in cycle 5 of a DIVU.
        op_i = 3'd3; src1_i = $urandom; src2_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_hilo", {hi_o, lo_o}, 64'h0);
        check("rst_mid_flags", {busy_o, done_o, dbz_o}, 3'b000);
        m_hi = 0; m_lo = 0;
        done_seen = 0;
        repeat (45) begin
            @(negedge clk);
            done_seen += int'(done_o);
        end
        check("rst_mid_no_done", done_seen, 0);
        check("rst_mid_hilo_after", {hi_o, lo_o}, 64'h0);
        @(posedge clk); #1;

        // Back-to-back MULT: the held second request is taken in the first done cycle.
        a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
        model(3'd0, a, b, eh, el, edbz, lat);
        model(3'd0, a2, b2, eh2, el2, edbz, lat);
        first = -1; second = -1;
        op_i = 3'd0; src1_i = a; src2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        src1_i = a2; src2_i = b2;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) check("b2b_stall_c1", stall_o, 1'b1);
            if (done_o) begin
                if (first < 0) begin
                    first = c;
                    check("b2b_first_res", {hi_o, lo_o}, {eh, el});
                end else if (second < 0) begin
                    second = c;
                    check("b2b_second_res", {hi_o, lo_o}, {eh2, el2});
                end
            end
            @(posedge clk); #1;
            if (first >= 0) start_i = 1'b0;
        end
        check("b2b_first_cycle", first, MUL_STAGES + 1);
        check("b2b_second_cycle", second, 2 * (MUL_STAGES + 1));
        m_hi = eh2; m_lo = el2;

        // Randomized mix of all operations.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
